// File: rtl/spi_slave_if.sv
// Wishbone register-port bundle shared by the SoC's bus peripherals.
// 32-bit data; dat_i flows master->slave, dat_o slave->master.
`timescale 1ns/1ps
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;
  logic        stall;

  modport master (output cyc, stb, we, sel, adr, dat_i, input dat_o, ack, stall);
  modport slave  (input cyc, stb, we, sel, adr, dat_i, output dat_o, ack, stall);
endinterface

// File: rtl/spi_slave.sv
// SPI target with oversampled sclk/mosi/ss_n and a Wishbone TX/RX/status port.
// Define SPI_SLAVE_IRQ_EN to add the level interrupt output and conf[6:4].
`timescale 1ns/1ps
module spi_slave #(
  parameter int unsigned CLKFREQ = 10000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sclk,
  input  logic mosi,
  input  logic ss_n,
  output logic miso,
  output logic miso_oe,
`ifdef SPI_SLAVE_IRQ_EN
  output logic irq,
`endif
  if_wb.slave  bus
);

  typedef enum logic {ST_IDLE, ST_DONE} bus_state_t;

`ifdef SPI_SLAVE_IRQ_EN
  localparam logic [7:0] CONF_MASK = 8'hFF;
`else
  localparam logic [7:0] CONF_MASK = 8'h8F;
`endif

  if (CLKFREQ == 0) begin : g_bad_clkfreq
    $error("spi_slave: CLKFREQ must be non-zero");
  end

  logic [2:0] sclk_q;
  logic [2:0] ss_q;
  logic [1:0] mosi_q;

  bus_state_t state;
  logic [7:0] conf;
  logic [7:0] tx_hold;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic       rx_full;
  logic       overrun;
  logic       underrun;
  logic       active;
  logic [2:0] bitcnt;

  // sclk and ss_n get a third stage for edge detection; mosi is taken from
  // stage 2 so all three inputs line up at the same clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q <= '0;
      mosi_q <= '0;
      // NOTE: ss_n history resets low so a master still selecting us when reset
      // is released cannot look like a fresh frame start.
      ss_q   <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      mosi_q <= {mosi_q[0], mosi};
      ss_q   <= {ss_q[1:0], ss_n};
    end
  end

  logic        sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic        frame_start, frame_end, do_sample, do_shift, tx_load, byte_done;
  logic        bus_req, wr_data, rd_data, wr_ctrl, rx_free;
  logic [7:0]  rx_byte;
  logic [31:0] status;

  assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
  assign lead_edge   = conf[1] ? sclk_fall : sclk_rise;
  assign trail_edge  = conf[1] ? sclk_rise : sclk_fall;
  assign frame_start = ~ss_q[1] & ss_q[2];
  assign frame_end   = ss_q[1] & ~ss_q[2];
  assign do_sample   = active & ~frame_end & (conf[0] ? trail_edge : lead_edge);
  assign do_shift    = active & ~frame_end & (conf[0] ? lead_edge : trail_edge);
  assign tx_load     = (frame_start & ~conf[0]) | (do_shift & (bitcnt == 3'd0));
  assign byte_done   = do_sample & (bitcnt == 3'd7);
  assign rx_byte     = {rx_sr[6:0], mosi_q[1]};

  assign bus_req = (state == ST_IDLE) & bus.cyc & bus.stb;
  assign wr_data = bus_req & bus.we & ~bus.adr[2];
  assign rd_data = bus_req & ~bus.we & ~bus.adr[2];
  assign wr_ctrl = bus_req & bus.we & bus.adr[2];
  // A data read in the same cycle as a completed byte frees the buffer for it.
  assign rx_free = ~rx_full | rd_data;
  assign status  = {8'h0, conf, 11'h0, active, underrun, overrun, ~tx_valid, rx_full};

  assign miso_oe   = active;
  assign bus.stall = 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      bus.ack   <= 1'b0;
      bus.dat_o <= '0;
      conf      <= '0;
      tx_hold   <= '0;
      tx_sr     <= '1;
      rx_sr     <= '0;
      rx_data   <= '0;
      tx_valid  <= 1'b0;
      rx_full   <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
      active    <= 1'b0;
      bitcnt    <= '0;
      miso      <= 1'b1;
`ifdef SPI_SLAVE_IRQ_EN
      irq       <= 1'b0;
`endif
    end else begin
      if (frame_end) begin
        active <= 1'b0;
        bitcnt <= '0;
      end else if (frame_start) begin
        active <= 1'b1;
        bitcnt <= '0;
      end else if (do_sample) begin
        rx_sr  <= rx_byte;
        bitcnt <= bitcnt + 3'd1;
      end

      if (tx_load)       tx_sr <= tx_valid ? tx_hold : 8'hFF;
      else if (do_shift) tx_sr <= {tx_sr[6:0], 1'b0};

      miso <= active ? tx_sr[7] : 1'b1;

      // NOTE: clears are issued before sets; the last non-blocking assignment
      // to a register wins, which gives sets priority in the same cycle.
      if (rd_data) rx_full <= 1'b0;
      if (wr_ctrl && bus.sel[0]) begin
        if (bus.dat_i[2]) overrun  <= 1'b0;
        if (bus.dat_i[3]) underrun <= 1'b0;
      end
      if (tx_load) begin
        if (tx_valid) tx_valid <= 1'b0;
        else          underrun <= 1'b1;
      end
      if (wr_data) begin
        tx_hold  <= bus.dat_i[7:0];
        tx_valid <= 1'b1;
      end
      if (byte_done) begin
        if (rx_free) begin
          rx_data <= rx_byte;
          rx_full <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (wr_ctrl && bus.sel[2] && !active) conf <= bus.dat_i[23:16] & CONF_MASK;

      case (state)
        ST_IDLE: begin
          if (bus.cyc && bus.stb) begin
            state   <= ST_DONE;
            bus.ack <= 1'b1;
            if (!bus.we) bus.dat_o <= bus.adr[2] ? status : {24'h0, rx_data};
          end
        end
        default: begin
          state   <= ST_IDLE;
          bus.ack <= 1'b0;
        end
      endcase

`ifdef SPI_SLAVE_IRQ_EN
      irq <= (rx_full & conf[4]) | (~tx_valid & conf[5]) | ((overrun | underrun) & conf[6]);
`endif
    end
  end

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.adr[31:3], bus.adr[1:0], bus.sel[3], bus.sel[1],
                             bus.dat_i[31:24], bus.dat_i[15:8]};

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: SPI master BFM plus Wishbone driver, with a
// transaction-level model predicting bus reads and bytes returned on miso.
`timescale 1ns/1ps
module tb_spi_slave;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic sclk   = 1'b0;
  logic mosi   = 1'b0;
  logic ss_n   = 1'b1;
  logic miso;
  logic miso_oe;
`ifdef SPI_SLAVE_IRQ_EN
  logic irq;
  localparam logic [7:0] CONF_KEEP = 8'hFF;
`else
  localparam logic [7:0] CONF_KEEP = 8'h8F;
`endif

  if_wb bus();

  spi_slave #(.CLKFREQ(100000000)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .sclk    (sclk),
    .mosi    (mosi),
    .ss_n    (ss_n),
    .miso    (miso),
    .miso_oe (miso_oe),
`ifdef SPI_SLAVE_IRQ_EN
    .irq     (irq),
`endif
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents as seen by software.
  logic [7:0] m_conf, m_tx_hold, m_rx_data, pend_out;
  logic       m_tx_valid, m_rx_full, m_ovr, m_udr, m_active;
  logic       cur_cpol, cur_cpha;
  logic [31:0] exp_rd[$];
  logic [7:0]  exp_miso[$];
  logic [7:0]  got_miso[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {8'h0, m_conf, 11'h0, m_active, m_udr, m_ovr, ~m_tx_valid, m_rx_full};
  endfunction

  function automatic logic m_irq();
    return (m_rx_full & m_conf[4]) | (~m_tx_valid & m_conf[5]) | ((m_ovr | m_udr) & m_conf[6]);
  endfunction

  // One TX register load: pending CPU byte if any, otherwise 0xFF and underrun.
  function automatic logic [7:0] m_load();
    if (m_tx_valid) begin
      m_tx_valid = 1'b0;
      return m_tx_hold;
    end
    m_udr = 1'b1;
    return 8'hFF;
  endfunction

  function automatic void m_rx(input logic [7:0] b);
    if (!m_rx_full) begin
      m_rx_data = b;
      m_rx_full = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endfunction

  // Monitor: compares every read ack and every byte the master collected.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (bus.ack && !bus.we) begin
        if (exp_rd.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: got %h with no read outstanding", bus.dat_o);
        end else begin
          check("wb_read", bus.dat_o, exp_rd.pop_front());
        end
      end
      while (got_miso.size() > 0) begin
        if (exp_miso.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL miso_unexpected: got %h with nothing predicted", got_miso.pop_front());
        end else begin
          check("miso_byte", {24'h0, got_miso.pop_front()}, {24'h0, exp_miso.pop_front()});
        end
      end
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- Wishbone driver ----------------
  task automatic wb_cycle(input logic we, input logic adr2, input logic [3:0] sel,
                          input logic [31:0] d);
    logic seen;
    seen = 1'b0;
    @(negedge clk_i);
    bus.cyc   = 1'b1;
    bus.stb   = 1'b1;
    bus.we    = we;
    bus.adr   = adr2 ? 32'h4 : 32'h0;
    bus.sel   = sel;
    bus.dat_i = d;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk_i);
      seen = bus.ack;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL wb_ack: no ack within 8 cycles");
    end
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic wb_write_data(input logic [7:0] b);
    wb_cycle(1'b1, 1'b0, 4'hF, {24'h0, b});
    m_tx_hold  = b;
    m_tx_valid = 1'b1;
  endtask

  task automatic wb_write_ctrl(input logic [3:0] sel, input logic [31:0] d);
    wb_cycle(1'b1, 1'b1, sel, d);
    if (sel[2] && !m_active) m_conf = d[23:16] & CONF_KEEP;
    if (sel[0]) begin
      if (d[2]) m_ovr = 1'b0;
      if (d[3]) m_udr = 1'b0;
    end
  endtask

  task automatic wb_read_data();
    exp_rd.push_back({24'h0, m_rx_data});
    wb_cycle(1'b0, 1'b0, 4'hF, 32'h0);
    m_rx_full = 1'b0;
  endtask

  task automatic wb_read_status();
    exp_rd.push_back(m_status());
    wb_cycle(1'b0, 1'b1, 4'hF, 32'h0);
  endtask

  task automatic set_mode(input logic [7:0] c);
    wb_write_ctrl(4'b0100, {8'h0, c, 16'h0});
    cur_cpol = c[1];
    cur_cpha = c[0];
    @(negedge clk_i);
    sclk = cur_cpol;
    repeat (4) @(negedge clk_i);
  endtask

  // ---------------- SPI master BFM ----------------
  task automatic half();
    repeat (8) @(negedge clk_i);
  endtask

  task automatic ss_low();
    @(negedge clk_i);
    sclk     = cur_cpol;
    ss_n     = 1'b0;
    m_active = 1'b1;
    if (!cur_cpha) pend_out = m_load();
    repeat (12) @(negedge clk_i);
  endtask

  task automatic ss_high();
    half();
    ss_n     = 1'b1;
    m_active = 1'b0;
    repeat (12) @(negedge clk_i);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
    got = 8'h0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cur_cpha) begin
        mosi = b[i];
        half();
        got  = {got[6:0], miso};
        sclk = ~cur_cpol;
        half();
        sclk = cur_cpol;
      end else begin
        half();
        sclk = ~cur_cpol;
        mosi = b[i];
        half();
        got  = {got[6:0], miso};
        sclk = cur_cpol;
      end
    end
    half();
  endtask

  task automatic spi_byte(input logic [7:0] b);
    logic [7:0] got;
    if (cur_cpha) pend_out = m_load();
    exp_miso.push_back(pend_out);
    spi_bits(b, 8, got);
    got_miso.push_back(got);
    m_rx(b);
    if (!cur_cpha) pend_out = m_load();
  endtask

  // ---------------- Test sequence ----------------
  initial begin
    logic [7:0] part;
    logic [7:0] rb;
    int nb;
    m_conf = '0; m_tx_hold = '0; m_rx_data = '0; pend_out = 8'hFF;
    m_tx_valid = 1'b0; m_rx_full = 1'b0; m_ovr = 1'b0; m_udr = 1'b0; m_active = 1'b0;
    cur_cpol = 1'b0; cur_cpha = 1'b0;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.sel = '0; bus.adr = '0; bus.dat_i = '0;

    repeat (5) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("reset_miso", {31'h0, miso}, 32'h1);
    check("reset_miso_oe", {31'h0, miso_oe}, 32'h0);
    check("reset_ack", {31'h0, bus.ack}, 32'h0);
    check("reset_dat_o", bus.dat_o, 32'h0);
`ifdef SPI_SLAVE_IRQ_EN
    check("reset_irq", {31'h0, irq}, 32'h0);
`endif
    wb_read_status();

    // Mode 0 single byte
    set_mode(8'h00);
    wb_write_data(8'hA5);
    ss_low();
    spi_byte(8'h3C);
    ss_high();
    wb_read_status();
    wb_read_data();
    wb_write_ctrl(4'b0001, 32'h0000_000C);

    // Mode 3 underrun, then W1C of underrun
    set_mode(8'h03);
    ss_low();
    spi_byte(8'($urandom));
    ss_high();
    wb_read_status();
    wb_write_ctrl(4'b0001, 32'h0000_0008);
    wb_read_status();
    wb_read_data();

    // Overrun: two bytes with no read in between
    set_mode(8'h00);
    ss_low(); spi_byte(8'h11); ss_high();
    ss_low(); spi_byte(8'h22); ss_high();
    wb_read_status();
    wb_read_data();
    wb_read_status();
    wb_write_ctrl(4'b0001, 32'h0000_000C);

    // Abort after 5 bits, then a clean frame
    ss_low();
    spi_bits(8'hF0, 5, part);
    ss_high();
    check("abort_miso_oe", {31'h0, miso_oe}, 32'h0);
    check("abort_miso", {31'h0, miso}, 32'h1);
    wb_read_status();
    ss_low(); spi_byte(8'h5A); ss_high();
    wb_read_data();
    wb_write_ctrl(4'b0001, 32'h0000_000C);

    // Back-to-back in mode 1 with an ignored conf write mid-frame
    set_mode(8'h01);
    wb_write_data(8'h12);
    ss_low();
    spi_byte(8'($urandom));
    wb_read_status();
    wb_write_data(8'h34);
    wb_write_ctrl(4'b0100, 32'h0003_0000);
    spi_byte(8'($urandom));
    ss_high();
    wb_read_status();
    wb_read_data();

    // Randomised frames in all modes
    for (int it = 0; it < 16; it++) begin
      set_mode(8'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) wb_write_data(8'($urandom));
      nb = $urandom_range(1, 3);
      ss_low();
      for (int k = 0; k < nb; k++) begin
        rb = 8'($urandom);
        spi_byte(rb);
        if ($urandom_range(0, 2) == 0) wb_write_data(8'($urandom));
      end
      ss_high();
      wb_read_status();
      if ($urandom_range(0, 1) == 1) wb_read_data();
      if ($urandom_range(0, 1) == 1) wb_write_ctrl(4'b0001, $urandom & 32'hC);
    end

`ifdef SPI_SLAVE_IRQ_EN
    // Interrupt on rx_full only
    set_mode(8'h10);
    wb_read_data();
    wb_write_ctrl(4'b0001, 32'h0000_000C);
    repeat (2) @(negedge clk_i);
    check("irq_idle", {31'h0, irq}, {31'h0, m_irq()});
    ss_low(); spi_byte(8'($urandom)); ss_high();
    check("irq_rx_full", {31'h0, irq}, {31'h0, m_irq()});
    wb_read_data();
    check("irq_hold", {31'h0, irq}, 32'h1);
    @(negedge clk_i);
    check("irq_cleared", {31'h0, irq}, {31'h0, m_irq()});
`endif

    repeat (10) @(negedge clk_i);
    check("rd_queue_drained", exp_rd.size(), 32'h0);
    check("miso_queue_drained", exp_miso.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
